// File: rtl/digiac_pkg.sv
// Shared Digiac timing constants and the CPU-speed divider clamp.
package digiac_pkg;
    localparam int DIGIAC_DIV_W       = 8;
    localparam int DIGIAC_DEFAULT_DIV = 50;
    localparam logic [4*DIGIAC_DIV_W-1:0] DIGIAC_VIA_PHASES = {8'd32, 8'd24, 8'd16, 8'd8};

    // A period below 2 clk would leave no room for cpu_clken1 inside the cycle.
    function automatic logic [31:0] clamp_div(input logic [31:0] v);
        return (v < 32'd2) ? 32'd2 : v;
    endfunction
endpackage

// File: rtl/digiac_phase_strobe.sv
// One registered peripheral enable: pulses the clk after the segment counter hits its phase.
module digiac_phase_strobe #(
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [DIV_W-1:0] cnt,
    input  logic [DIV_W-1:0] phase,
    input  logic             halted,
    output logic             strobe
);
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) strobe <= 1'b0;
        else          strobe <= (cnt == phase) && !halted;
    end
endmodule

// File: rtl/digiac_cycle_gen.sv
// Digiac bus-cycle generator: CPU enable, delayed access strobe, phase enables, phi2,
// runtime divider, wait-state stretching and halt/single-step.
module digiac_cycle_gen
    import digiac_pkg::*;
#(
    parameter int DIV_W       = DIGIAC_DIV_W,
    parameter int DEFAULT_DIV = DIGIAC_DEFAULT_DIV,
    parameter int NUM_STROBES = 4,
    parameter logic [NUM_STROBES*DIV_W-1:0] STROBE_PHASE = DIGIAC_VIA_PHASES,
    parameter int WAIT_W      = 2,
    parameter int CNT_W       = 32
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [DIV_W-1:0]       div_val,
    input  logic                   div_load,
    input  logic [WAIT_W-1:0]      wait_req,
    input  logic                   run,
    input  logic                   step,
    output logic                   cpu_clken,
    output logic                   cpu_clken1,
    output logic [NUM_STROBES-1:0] periph_clken,
    output logic                   phi2,
    output logic                   halted,
    output logic [CNT_W-1:0]       cycle_count
);
    logic [DIV_W-1:0]  cnt, period, pending;
    logic [WAIT_W-1:0] wait_rem, wait_eff;
    logic              step_lat, step_eff, go;
    logic              seg_end, start, halt_now, wait_seg;

    // With a 2-clk period the wait sample and the first segment end share a clk,
    // so the freshly requested wait must be honoured directly.
    always_comb begin
        seg_end  = !halted && (cnt == period - DIV_W'(1));
        wait_eff = cpu_clken1 ? wait_req : wait_rem;
        step_eff = step_lat || (step && !run);
        go       = run || step_eff;
        wait_seg = seg_end && (wait_eff != '0);
        halt_now = seg_end && (wait_eff == '0) && !go;
        start    = (seg_end && (wait_eff == '0) && go) || (halted && go);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt         <= '0;
            period      <= DIV_W'(DEFAULT_DIV);
            pending     <= DIV_W'(DEFAULT_DIV);
            wait_rem    <= '0;
            step_lat    <= 1'b0;
            halted      <= 1'b0;
            cpu_clken   <= 1'b0;
            cpu_clken1  <= 1'b0;
            phi2        <= 1'b0;
            cycle_count <= '0;
        end else begin
            if (start) begin
                cnt    <= '0;
                period <= pending;
            end else if (wait_seg) begin
                cnt <= '0;
            end else if (!halt_now && !halted) begin
                cnt <= cnt + DIV_W'(1);
            end

            if (div_load) pending <= DIV_W'(clamp_div(32'(div_val)));

            wait_rem <= wait_seg ? wait_eff - WAIT_W'(1) : wait_eff;
            step_lat <= start ? 1'b0 : step_eff;

            if (halt_now)   halted <= 1'b1;
            else if (start) halted <= 1'b0;

            cpu_clken  <= start;
            cpu_clken1 <= cpu_clken;

            // Set wins over clear so a 2-clk period still sees phi2 at cycle start.
            if (start)                    phi2 <= 1'b1;
            else if (cnt == (period >> 1)) phi2 <= 1'b0;

            if (start) cycle_count <= cycle_count + CNT_W'(1);
        end
    end

    for (genvar i = 0; i < NUM_STROBES; i++) begin : g_strobe
        digiac_phase_strobe #(.DIV_W(DIV_W)) u_strobe (
            .clk     (clk),
            .reset_n (reset_n),
            .cnt     (cnt),
            .phase   (STROBE_PHASE[i*DIV_W +: DIV_W]),
            .halted  (halted),
            .strobe  (periph_clken[i])
        );
    end
endmodule

// File: tb/tb_digiac_cycle_gen.sv
// Directed bench for digiac_cycle_gen: table of per-cycle vectors plus halt/step/reset sequences.
module tb_digiac_cycle_gen;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [7:0]  div_val = '0;
    logic        div_load = 1'b0;
    logic [1:0]  wait_req = '0;
    logic        run = 1'b1;
    logic        step = 1'b0;
    logic        cpu_clken, cpu_clken1, phi2, halted;
    logic [3:0]  periph_clken;
    logic [31:0] cycle_count;

    logic        clken_b, clken1_b, phi2_b, halted_b;
    logic [0:0]  periph_b;
    logic [3:0]  cc_b;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    digiac_cycle_gen dut (
        .clk(clk), .reset_n(reset_n), .div_val(div_val), .div_load(div_load),
        .wait_req(wait_req), .run(run), .step(step), .cpu_clken(cpu_clken),
        .cpu_clken1(cpu_clken1), .periph_clken(periph_clken), .phi2(phi2),
        .halted(halted), .cycle_count(cycle_count)
    );

    digiac_cycle_gen #(.DIV_W(8), .DEFAULT_DIV(4), .NUM_STROBES(1), .STROBE_PHASE(8'd1),
                       .WAIT_W(2), .CNT_W(4)) dut_w (
        .clk(clk), .reset_n(reset_n), .div_val(8'd0), .div_load(1'b0),
        .wait_req(2'd0), .run(1'b1), .step(1'b0), .cpu_clken(clken_b),
        .cpu_clken1(clken1_b), .periph_clken(periph_b), .phi2(phi2_b),
        .halted(halted_b), .cycle_count(cc_b)
    );

    typedef struct {
        int load_at; int div; int wait_at; int wreq;
        int len; int s0; int s1; int s2; int s3; int phi;
    } vec_t;

    vec_t vecs[15];

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Starts on a cpu_clken sample, ends on the next one.
    task automatic run_entry(input vec_t v, input int idx);
        int len, ph, c1n, c1pos;
        int s[4];
        len = 0; ph = 0; c1n = 0; c1pos = -1;
        for (int i = 0; i < 4; i++) s[i] = 0;
        while (1) begin
            for (int i = 0; i < 4; i++) s[i] += int'(periph_clken[i]);
            ph += int'(phi2);
            if (cpu_clken1) begin c1n++; c1pos = len; end
            div_load = (len == v.load_at);
            div_val  = 8'(v.div);
            wait_req = (len == v.wait_at) ? 2'(v.wreq) : 2'd0;
            tick();
            div_load = 1'b0;
            wait_req = 2'd0;
            len++;
            if (cpu_clken || len > 400) break;
        end
        chk($sformatf("v%0d_len", idx), len, v.len);
        chk($sformatf("v%0d_s0", idx), s[0], v.s0);
        chk($sformatf("v%0d_s1", idx), s[1], v.s1);
        chk($sformatf("v%0d_s2", idx), s[2], v.s2);
        chk($sformatf("v%0d_s3", idx), s[3], v.s3);
        if (v.phi >= 0) chk($sformatf("v%0d_phi2", idx), ph, v.phi);
        chk($sformatf("v%0d_c1cnt", idx), c1n, 1);
        chk($sformatf("v%0d_c1pos", idx), c1pos, 1);
    endtask

    initial begin
        int first, pulses, bad_halt, cc0;

        vecs[0]  = '{-1,  0, -1, 0,  50, 1, 1, 1, 1, 26};
        vecs[1]  = '{-1,  0,  1, 2, 150, 3, 3, 3, 3, 26};
        vecs[2]  = '{-1,  0,  5, 1,  50, 1, 1, 1, 1, 26};
        vecs[3]  = '{20, 10, -1, 0,  50, 1, 1, 1, 1, 26};
        vecs[4]  = '{-1,  0, -1, 0,  10, 1, 0, 0, 0,  6};
        vecs[5]  = '{-1,  0,  1, 3,  40, 4, 0, 0, 0,  6};
        vecs[6]  = '{ 0,  1, -1, 0,  10, 1, 0, 0, 0,  6};
        vecs[7]  = '{-1,  0, -1, 0,   2, 0, 0, 0, 0, -1};
        vecs[8]  = '{-1,  0,  1, 1,   4, 0, 0, 0, 0, -1};
        vecs[9]  = '{ 0, 50, -1, 0,   2, 0, 0, 0, 0, -1};
        vecs[10] = '{-1,  0, -1, 0,  50, 1, 1, 1, 1, 26};
        vecs[11] = '{49, 10, -1, 0,  50, 1, 1, 1, 1, 26};
        vecs[12] = '{-1,  0, -1, 0,  50, 1, 1, 1, 1, 26};
        vecs[13] = '{ 0, 50, -1, 0,  10, 1, 0, 0, 0,  6};
        vecs[14] = '{-1,  0, -1, 0,  50, 1, 1, 1, 1, 26};

        // Reset state
        repeat (3) tick();
        chk("rst_clken", cpu_clken, 0);
        chk("rst_clken1", cpu_clken1, 0);
        chk("rst_periph", periph_clken, 0);
        chk("rst_phi2", phi2, 0);
        chk("rst_halted", halted, 0);
        chk("rst_count", cycle_count, 0);
        reset_n = 1'b1;

        first = -1;
        for (int k = 1; k <= 60 && first < 0; k++) begin
            tick();
            if (cpu_clken) first = k;
        end
        chk("first_clken", first, 50);
        chk("first_count", cycle_count, 1);

        for (int i = 0; i < 15; i++) run_entry(vecs[i], i);
        chk("table_count", cycle_count, 16);

        // Halt at the cycle end
        run = 1'b0;
        first = -1; pulses = 0;
        for (int n = 1; n <= 50; n++) begin
            tick();
            if (cpu_clken) pulses++;
            if (halted && first < 0) first = n;
        end
        chk("halt_at", first, 50);
        chk("halt_no_clken", pulses, 0);
        cc0 = int'(cycle_count);
        pulses = 0; bad_halt = 0;
        for (int n = 0; n < 500; n++) begin
            tick();
            if (cpu_clken) pulses++;
            if (periph_clken != 0 || !halted) bad_halt++;
        end
        chk("halted_clken", pulses, 0);
        chk("halted_quiet", bad_halt, 0);

        // Two steps 20 clk apart
        step = 1'b1; tick(); step = 1'b0;
        chk("step_clken", cpu_clken, 1);
        chk("step_halted", halted, 0);
        pulses = 1;
        for (int n = 1; n <= 300; n++) begin
            step = (n == 20);
            tick();
            step = 1'b0;
            if (cpu_clken) pulses++;
        end
        chk("two_steps", pulses, 2);
        chk("two_steps_count", cycle_count, cc0 + 2);
        chk("two_steps_halted", halted, 1);

        // run=1 releases; step while running is ignored
        run = 1'b1; tick();
        chk("run_release", cpu_clken, 1);
        chk("run_release_halted", halted, 0);
        pulses = 0;
        for (int n = 0; n < 120; n++) begin
            step = (n == 5);
            if (n == 10) run = 1'b0;
            tick();
            step = 1'b0;
            if (cpu_clken) pulses++;
        end
        chk("step_in_run_ignored", pulses, 0);
        chk("step_in_run_halted", halted, 1);

        // Two steps inside one released cycle give one extra cycle
        step = 1'b1; tick(); step = 1'b0;
        pulses = int'(cpu_clken);
        for (int n = 1; n <= 300; n++) begin
            step = (n == 20 || n == 30);
            tick();
            step = 1'b0;
            if (cpu_clken) pulses++;
        end
        chk("absorbed_step", pulses, 2);

        // Reset in the middle of a cycle
        run = 1'b1; tick();
        chk("resume_clken", cpu_clken, 1);
        repeat (30) tick();
        #2 reset_n = 1'b0;
        #1;
        chk("mid_rst_clken", cpu_clken, 0);
        chk("mid_rst_clken1", cpu_clken1, 0);
        chk("mid_rst_periph", periph_clken, 0);
        chk("mid_rst_phi2", phi2, 0);
        chk("mid_rst_halted", halted, 0);
        chk("mid_rst_count", cycle_count, 0);
        tick(); tick();
        chk("rst_hold_clken", cpu_clken, 0);
        reset_n = 1'b1;
        first = -1;
        for (int k = 1; k <= 64; k++) begin
            tick();
            if (cpu_clken && first < 0) first = k;
            if (k == 60) chk("wrap_pre", cc_b, 15);
            if (k == 64) begin
                chk("wrap_zero", cc_b, 0);
                chk("wrap_clken", clken_b, 1);
            end
        end
        chk("rst_first_clken", first, 50);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running want finished");
        $fatal(1, "timeout");
    end
endmodule
